// File: rtl/config_arbiter_if.sv
// rtl/config_arbiter_if.sv - config write bus interface
//
// Purpose: carries one config write (addr, data, valid) from a single master
//          to a config splitter / decoder.
// Signals:
//   addr   ADDR_WIDTH  write address
//   data   DATA_WIDTH  write data
//   valid  1           one-cycle write strobe
// Modports: m (driver), s (receiver)
interface config_i #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;

  modport m (output addr, output data, output valid);
  modport s (input addr, input data, input valid);
endinterface

// File: rtl/config_arbiter.sv
// rtl/config_arbiter.sv - round-robin arbiter sharing one config write bus
//
// Purpose: accepts writes from NUM_REQUESTERS masters with round-robin
//          priority, registers the winner onto a single config_i master port
//          and enforces MIN_GAP idle cycles after each issued write.
// Ports:
//   clk        in   1                        clock
//   rst_n      in   1                        async assert, active-low reset
//   req_valid  in   NUM_REQUESTERS           per-requester write request
//   req_ready  out  NUM_REQUESTERS           per-requester accept (one-hot/zero)
//   req_addr   in   NUM_REQUESTERS*ADDR_WIDTH per-requester address
//   req_data   in   NUM_REQUESTERS*DATA_WIDTH per-requester data
//   out        config_i.m                    arbitrated write (addr, data, valid)
//   grant_idx  out  IDX_W                    requester behind current out.valid
//   busy       out  1                        out.valid high or gap pending
module config_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int MIN_GAP        = 0,
  localparam int IDX_W         = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_REQUESTERS-1:0]                  req_valid,
  output logic [NUM_REQUESTERS-1:0]                  req_ready,
  input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]  req_data,
  config_i.m                                         out,
  output logic [IDX_W-1:0]                           grant_idx,
  output logic                                       busy
);

  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  logic [IDX_W-1:0] last_grant;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             grant_ok;

  // Search starts one past the previous winner so every continuously
  // requesting master is served once per NUM_REQUESTERS grants.
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQUESTERS);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Eligibility looks only at the registered gap count, so a request that
  // shows up as the count reaches zero waits for the following cycle.
  // rst_n is included so req_ready is low for the whole reset assertion.
  assign grant_ok = rst_n && (gap_cnt == '0) && found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      req_ready[i] = grant_ok && (winner == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.valid  <= 1'b0;
      out.addr   <= '0;
      out.data   <= '0;
      grant_idx  <= '0;
      gap_cnt    <= '0;
      last_grant <= IDX_W'(NUM_REQUESTERS - 1);
    end else begin
      out.valid <= grant_ok;
      if (grant_ok) begin
        out.addr   <= req_addr[winner];
        out.data   <= req_data[winner];
        grant_idx  <= winner;
        last_grant <= winner;
        gap_cnt    <= GAP_W'(MIN_GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  assign busy = out.valid || (gap_cnt != '0);

endmodule

// File: tb/tb_config_arbiter.sv
// tb/tb_config_arbiter.sv - self-checking bench for config_arbiter
//
// Purpose: drives two arbiter instances (u0: 3 requesters, MIN_GAP=0;
//          u1: 2 requesters, MIN_GAP=2) with directed and random writes and
//          compares every output against a behavioural model each cycle.
// Ports: none (top-level bench).
module tb_config_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus store, indexed [instance][requester]
  logic [2:0]        sv [2];
  logic [2:0][31:0]  sa [2];
  logic [2:0][63:0]  sd [2];

  logic [2:0]        v0, r0;
  logic [2:0][31:0]  a0;
  logic [2:0][63:0]  d0;
  logic [1:0]        g0;
  logic              busy0;
  logic [1:0]        v1, r1;
  logic [1:0][31:0]  a1;
  logic [1:0][63:0]  d1;
  logic [0:0]        g1;
  logic              busy1;

  assign v0 = sv[0];
  assign a0 = sa[0];
  assign d0 = sd[0];
  assign v1 = sv[1][1:0];
  assign a1 = sa[1][1:0];
  assign d1 = sd[1][1:0];

  config_i #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) cfg0 ();
  config_i #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) cfg1 ();

  config_arbiter #(.NUM_REQUESTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(64), .MIN_GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0),
    .req_addr(a0), .req_data(d0), .out(cfg0), .grant_idx(g0), .busy(busy0)
  );

  config_arbiter #(.NUM_REQUESTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .MIN_GAP(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1),
    .req_addr(a1), .req_data(d1), .out(cfg1), .grant_idx(g1), .busy(busy1)
  );

  // Observed outputs gathered per instance
  logic [2:0]  o_rdy  [2];
  logic        o_vld  [2];
  logic [31:0] o_addr [2];
  logic [63:0] o_data [2];
  logic [1:0]  o_idx  [2];
  logic        o_busy [2];

  assign o_rdy[0]  = r0;
  assign o_rdy[1]  = {1'b0, r1};
  assign o_vld[0]  = cfg0.valid;
  assign o_vld[1]  = cfg1.valid;
  assign o_addr[0] = cfg0.addr;
  assign o_addr[1] = cfg1.addr;
  assign o_data[0] = cfg0.data;
  assign o_data[1] = cfg1.data;
  assign o_idx[0]  = g0;
  assign o_idx[1]  = {1'b0, g1};
  assign o_busy[0] = busy0;
  assign o_busy[1] = busy1;

  // Reference model state
  int          m_last [2];
  int          m_gap  [2];
  bit          m_vld  [2];
  logic [31:0] m_addr [2];
  logic [63:0] m_data [2];
  int          m_idx  [2];
  int          last_w [2];
  bit          pend   [2][3];
  logic [31:0] pend_a [2][3];
  logic [63:0] pend_d [2][3];

  function automatic int nreq(input int n);
    return (n == 0) ? 3 : 2;
  endfunction

  function automatic int gap_of(input int n);
    return (n == 0) ? 0 : 2;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Winner for this cycle: first valid requester after the previous winner,
  // only when no gap is outstanding; -1 when nobody may be granted.
  function automatic int pick(input int n);
    if (m_gap[n] != 0) return -1;
    for (int k = 1; k <= nreq(n); k++) begin
      int c;
      c = (m_last[n] + k) % nreq(n);
      if (sv[n][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_last[n] = nreq(n) - 1;
      m_gap[n]  = 0;
      m_vld[n]  = 1'b0;
      m_addr[n] = '0;
      m_data[n] = '0;
      m_idx[n]  = 0;
      last_w[n] = -1;
      for (int i = 0; i < 3; i++) pend[n][i] = 1'b0;
    end
  endtask

  task automatic clear_stim();
    for (int n = 0; n < 2; n++) begin
      sv[n] = '0;
      sa[n] = '0;
      sd[n] = '0;
    end
  endtask

  task automatic check_outputs(input int n);
    int p;
    logic [2:0] er;
    p  = pick(n);
    er = '0;
    if (p >= 0) er[p] = 1'b1;
    check_eq($sformatf("u%0d ready", n), 64'(o_rdy[n]), 64'(er));
    check_eq($sformatf("u%0d valid", n), 64'(o_vld[n]), 64'(m_vld[n]));
    check_eq($sformatf("u%0d addr", n), 64'(o_addr[n]), 64'(m_addr[n]));
    check_eq($sformatf("u%0d data", n), o_data[n], m_data[n]);
    check_eq($sformatf("u%0d grant_idx", n), 64'(o_idx[n]), 64'(m_idx[n]));
    check_eq($sformatf("u%0d busy", n), 64'(o_busy[n]), 64'(m_vld[n] || (m_gap[n] != 0)));
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // retire accepted requests just after the rising edge.
  task automatic step();
    int w [2];
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < nreq(n); i++) begin
        if (pend[n][i]) begin
          assert (sv[n][i] && sa[n][i] == pend_a[n][i] && sd[n][i] == pend_d[n][i])
            else $error("hold rule broken on u%0d requester %0d", n, i);
        end
      end
      check_outputs(n);
      w[n] = pick(n);
      for (int i = 0; i < nreq(n); i++) begin
        pend[n][i]   = sv[n][i] && (i != w[n]);
        pend_a[n][i] = sa[n][i];
        pend_d[n][i] = sd[n][i];
      end
      if (w[n] >= 0) begin
        m_vld[n]  = 1'b1;
        m_addr[n] = sa[n][w[n]];
        m_data[n] = sd[n][w[n]];
        m_idx[n]  = w[n];
        m_last[n] = w[n];
        m_gap[n]  = gap_of(n);
      end else begin
        m_vld[n] = 1'b0;
        if (m_gap[n] > 0) m_gap[n]--;
      end
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      last_w[n] = w[n];
      if (w[n] >= 0) sv[n][w[n]] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_stim();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic present(input int n, input int i, input logic [31:0] a, input logic [63:0] d);
    sv[n][i] = 1'b1;
    sa[n][i] = a;
    sd[n][i] = d;
  endtask

  task automatic rand_fill();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < nreq(n); i++) begin
        if (!sv[n][i] && $urandom_range(0, 2) != 0)
          present(n, i, $urandom, {$urandom, $urandom});
      end
    end
  endtask

  initial begin
    int sent;
    bit exp_v;
    bit exp_b;

    // Reset: outputs cleared and ready held low even with a pending request
    rst_n = 1'b0;
    clear_stim();
    model_reset();
    present(0, 0, 32'h10, 64'hAB);
    repeat (2) @(negedge clk);
    check_eq("rst ready0", 64'(r0), 64'd0);
    check_eq("rst ready1", 64'(r1), 64'd0);
    check_eq("rst valid0", 64'(cfg0.valid), 64'd0);
    check_eq("rst addr0", 64'(cfg0.addr), 64'd0);
    check_eq("rst data0", cfg0.data, 64'd0);
    check_eq("rst busy1", 64'(busy1), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First write after reset: requester 0, one cycle of latency
    step();
    check_eq("first valid", 64'(cfg0.valid), 64'd1);
    check_eq("first addr", 64'(cfg0.addr), 64'h10);
    check_eq("first data", cfg0.data, 64'hAB);
    check_eq("first idx", 64'(g0), 64'd0);

    // Round robin under continuous load, back-to-back
    do_reset();
    for (int i = 0; i < 3; i++) present(0, i, 32'h100 + i, 64'(i));
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("rr valid", 64'(cfg0.valid), 64'd1);
      check_eq("rr order", 64'(g0), 64'(k % 3));
      present(0, k % 3, 32'h200 + k, 64'(k + 16));
    end

    // Gap enforcement: requester 1 of u1 issues three writes
    do_reset();
    present(1, 1, 32'hA000, 64'h1);
    sent = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_w[1] == 1 && sent < 3) begin
        present(1, 1, 32'hA000 + sent, 64'(sent + 1));
        sent++;
      end
      exp_v = (k + 1 == 1) || (k + 1 == 4) || (k + 1 == 7);
      // Re-issue cycles 3 and 6 have valid low and gap already zero
      exp_b = (k + 1 == 1) || (k + 1 == 2) || (k + 1 == 4) || (k + 1 == 5) ||
              (k + 1 == 7) || (k + 1 == 8);
      check_eq("gap valid", 64'(cfg1.valid), 64'(exp_v));
      check_eq("gap busy", 64'(busy1), 64'(exp_b));
    end

    // Rotation after a single grant to requester 1
    do_reset();
    present(0, 1, 32'h300, 64'h30);
    step();
    check_eq("rot first", 64'(g0), 64'd1);
    present(0, 0, 32'h310, 64'h31);
    present(0, 1, 32'h311, 64'h32);
    step();
    check_eq("rot second", 64'(g0), 64'd0);
    step();
    check_eq("rot third", 64'(g0), 64'd1);
    check_eq("rot addr", 64'(cfg0.addr), 64'h311);

    // Asynchronous reset while out.valid is high
    do_reset();
    for (int i = 0; i < 3; i++) present(0, i, 32'h400 + i, 64'(i + 64));
    step();
    step();
    check_eq("pre-reset valid", 64'(cfg0.valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async valid", 64'(cfg0.valid), 64'd0);
    check_eq("async busy", 64'(busy0), 64'd0);
    check_eq("async ready", 64'(r0), 64'd0);
    clear_stim();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    present(0, 0, 32'h500, 64'h50);
    present(0, 1, 32'h501, 64'h51);
    step();
    check_eq("post-reset idx", 64'(g0), 64'd0);
    check_eq("post-reset addr", 64'(cfg0.addr), 64'h500);

    // Hold: requester 0 waits behind requester 1 and the gap
    do_reset();
    present(1, 1, 32'h600, 64'h60);
    step();
    present(1, 0, 32'hCAFE0000, 64'h0123456789ABCDEF);
    present(1, 1, 32'h601, 64'h61);
    repeat (3) step();
    check_eq("hold valid", 64'(cfg1.valid), 64'd1);
    check_eq("hold idx", 64'(g1), 64'd0);
    check_eq("hold addr", 64'(cfg1.addr), 64'hCAFE0000);
    check_eq("hold data", cfg1.data, 64'h0123456789ABCDEF);

    // Random traffic on both instances
    do_reset();
    repeat (600) begin
      rand_fill();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
